io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 The block SHALL have one clock and one reset: rst is synchronous and active-high, sampled only on the rising edge of clk.
REQ-002 The block SHALL have parameter NUM_BTN, default 4, giving the number of button inputs (legal 1..7).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 port_id  input  8  CPU port address, valid for both IN and OUT.
REQ-006 out_port  input  8  CPU write data, qualified by io_strb.
REQ-007 io_strb  input  1  one-cycle write strobe from the CPU execute stage.
REQ-008 in_port  output  8  read data to the CPU; combinational from port_id and internal registers.
REQ-009 interrupt  output  1  level interrupt request to the CPU input_interrupt.
REQ-010 switches  input  8  board switches, asynchronous.
REQ-011 buttons  input  NUM_BTN  board buttons, asynchronous.
REQ-012 leds  output  8  LED drive register.

Function
REQ-013 Port map SHALL be: 0x20 switches (R), 0x21 synced buttons zero-extended (R), 0x40 LED (R/W), 0x80 reload low (R/W), 0x81 reload high (R/W), 0x82 timer control (R/W; bit0 EN, bit1 AUTO, others read 0), 0x83 int status (R, write-1-to-clear), 0x84 int mask (R/W).
REQ-014 A register write SHALL occur on the rising edge where io_strb=1 and port_id matches; the new value is visible on leds/in_port from the next cycle.
REQ-015 Writes to unmapped or read-only ports SHALL be ignored; reads of unmapped ports SHALL return 0x00.
REQ-016 in_port SHALL have no combinational path from switches or buttons; 0x20 reads a 2-flop-synchronized copy of switches.
REQ-017 Timer: writing 0x82 with EN=1 SHALL load the 16-bit counter from {reload high, reload low} on that edge.
REQ-018 While EN=1 and counter!=0 the counter SHALL decrement by 1 each cycle.
REQ-019 While EN=1 and counter==0: status bit0 SHALL set; if AUTO=1 the counter SHALL reload from reload value (period = reload+1 cycles), else EN SHALL clear and the counter holds 0.
REQ-020 Writing 0x82 with EN=0 SHALL stop the counter at its current value; no event fires.
REQ-021 Buttons SHALL pass a 2-flop synchronizer; a synchronized 0->1 transition on button n SHALL set status bit n+1 on the following edge (3rd edge after first sampled high).
REQ-022 Status bits SHALL be sticky until cleared by writing 1 to that bit at 0x83; writing 0 SHALL have no effect; bits above NUM_BTN read 0.
REQ-023 If a set event and a W1C of the same bit coincide, the set SHALL win.
REQ-024 interrupt SHALL equal OR of (status AND mask), computed from registered values only.
REQ-025 Writes to reload registers while the timer runs SHALL NOT affect the current count, only the next load.

Reset
REQ-026 On rst: leds=0x00, reload=0x0000, control=0x00, counter=0x0000, status=0x00, mask=0x00, all synchronizer and edge flops=0; hence interrupt=0 the cycle after rst.
REQ-027 rst mid-count SHALL abort the timer with no status event; rst SHALL take priority over a coincident io_strb write.

Structure
REQ-028 Port address constants, control bit indices and status bit indices SHALL live in shared package io_responder_pkg.
REQ-029 The synchronizer plus rising-edge detector SHALL be sub-module btn_sync_edge, instantiated once per button (vector form allowed).

Verification
REQ-030 Write 0x5A to 0x40 with io_strb -> leds=0x5A next cycle; read 0x40 -> in_port=0x5A; read 0x99 -> 0x00.
REQ-031 reload=0x0003, control=0x03, mask=0x01 -> status bit0 and interrupt rise 4 cycles after load, then every 4 cycles.
REQ-032 reload=0x0002, control=0x01 -> single event after 3 cycles, then control reads 0x00, counter stays 0.
REQ-033 Pulse buttons[2] high, mask=0x08 -> status=0x08 on 3rd edge, interrupt=1; write 0x08 to 0x83 -> status=0x00, interrupt=0 next cycle.
REQ-034 W1C of bit0 on the same edge the timer hits 0 -> status bit0 remains 1, interrupt stays 1.
REQ-035 Assert rst while timer runs and status=0x01 -> all registers read reset values, no event for 20 cycles.

Source files
------------

// File: rtl/io_responder_pkg.sv
// Shared port map, control/status bit positions and timer control layout for io_responder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package io_responder_pkg;

    // CPU port addresses
    localparam logic [7:0] PORT_SW     = 8'h20;
    localparam logic [7:0] PORT_BTN    = 8'h21;
    localparam logic [7:0] PORT_LED    = 8'h40;
    localparam logic [7:0] PORT_RLD_LO = 8'h80;
    localparam logic [7:0] PORT_RLD_HI = 8'h81;
    localparam logic [7:0] PORT_CTRL   = 8'h82;
    localparam logic [7:0] PORT_STAT   = 8'h83;
    localparam logic [7:0] PORT_MASK   = 8'h84;

    // Timer control bit indices
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;

    // Interrupt status bit indices: timer at bit0, button n at bit n+1
    localparam int STAT_TMR  = 0;
    localparam int STAT_BTN0 = 1;

    // Packed so that en lands on CTRL_EN and auto_rl on CTRL_AUTO
    typedef struct packed {
        logic auto_rl;
        logic en;
    } tmr_ctrl_t;

    // Control register as seen by a CPU read: unused bits read 0
    function automatic logic [7:0] ctrl_rd(input tmr_ctrl_t c);
        return {6'b0, c};
    endfunction

endpackage

// File: rtl/io_responder_btn_sync.sv
// btn_sync_edge: 2-flop synchronizer plus rising-edge detector, one lane per button.
// Latency: btn_sync 2 edges after input; btn_rise asserted for 1 cycle alongside first synced high.
// Backpressure: none; free-running.
// Ports: clk, rst (sync active-high), btn_async[W] in, btn_sync[W] out, btn_rise[W] out.
module btn_sync_edge #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] btn_async,
    output logic [W-1:0] btn_sync,
    output logic [W-1:0] btn_rise
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;   // previous synced value, for edge detection

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= btn_async;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign btn_sync = s2;
    assign btn_rise = s2 & ~s3;

endmodule

// File: rtl/io_responder.sv
// CPU I/O responder: switches/buttons/LEDs, 16-bit reload timer and W1C interrupt status/mask.
// Latency: writes visible next cycle; in_port is combinational from port_id and registers only.
// Backpressure: none; every io_strb write is accepted on its edge.
// Ports: clk, rst, port_id, out_port, io_strb (CPU side), in_port, interrupt (to CPU),
//        switches, buttons (async board inputs), leds (LED drive).
module io_responder
    import io_responder_pkg::*;
#(
    parameter int NUM_BTN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         port_id,
    input  logic [7:0]         out_port,
    input  logic               io_strb,
    output logic [7:0]         in_port,
    output logic               interrupt,
    input  logic [7:0]         switches,
    input  logic [NUM_BTN-1:0] buttons,
    output logic [7:0]         leds
);

    logic [7:0]         sw_s1;
    logic [7:0]         sw_s2;
    logic [NUM_BTN-1:0] btn_sync;
    logic [NUM_BTN-1:0] btn_rise;

    logic [7:0]         rld_lo;
    logic [7:0]         rld_hi;
    tmr_ctrl_t          ctrl;
    logic [15:0]        counter;
    logic [NUM_BTN:0]   status;
    logic [7:0]         mask;

    logic               wr_ctrl;
    logic               wr_stat;
    logic               tmr_evt;
    logic [NUM_BTN:0]   stat_set;
    logic [NUM_BTN:0]   stat_clr;

    btn_sync_edge #(.W(NUM_BTN)) u_btn (
        .clk       (clk),
        .rst       (rst),
        .btn_async (buttons),
        .btn_sync  (btn_sync),
        .btn_rise  (btn_rise)
    );

    assign wr_ctrl = io_strb && (port_id == PORT_CTRL);
    assign wr_stat = io_strb && (port_id == PORT_STAT);

    // A control write on the same edge overrides the expiry so no event fires
    assign tmr_evt  = ctrl.en && (counter == 16'd0) && !wr_ctrl;
    assign stat_set = {btn_rise, tmr_evt};
    assign stat_clr = wr_stat ? out_port[NUM_BTN:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            leds    <= '0;
            rld_lo  <= '0;
            rld_hi  <= '0;
            ctrl    <= '0;
            counter <= '0;
            status  <= '0;
            mask    <= '0;
        end else begin
            sw_s1 <= switches;
            sw_s2 <= sw_s1;

            if (io_strb && port_id == PORT_LED)    leds   <= out_port;
            if (io_strb && port_id == PORT_RLD_LO) rld_lo <= out_port;
            if (io_strb && port_id == PORT_RLD_HI) rld_hi <= out_port;
            if (io_strb && port_id == PORT_MASK)   mask   <= out_port;

            if (wr_ctrl) begin
                ctrl.en      <= out_port[CTRL_EN];
                ctrl.auto_rl <= out_port[CTRL_AUTO];
                if (out_port[CTRL_EN])
                    counter <= {rld_hi, rld_lo};
            end else if (ctrl.en) begin
                if (counter != 16'd0)
                    counter <= counter - 16'd1;
                else if (ctrl.auto_rl)
                    counter <= {rld_hi, rld_lo};
                else
                    ctrl.en <= 1'b0;
            end

            // Set has priority over a coincident clear
            status <= (status & ~stat_clr) | stat_set;
        end
    end

    assign interrupt = |(status & mask[NUM_BTN:0]);

    always_comb begin
        logic [7:0] rd_btn;
        logic [7:0] rd_stat;
        rd_btn                 = '0;
        rd_btn[NUM_BTN-1:0]    = btn_sync;
        rd_stat                = '0;
        rd_stat[NUM_BTN:0]     = status;
        in_port                = 8'h00;
        case (port_id)
            PORT_SW:     in_port = sw_s2;
            PORT_BTN:    in_port = rd_btn;
            PORT_LED:    in_port = leds;
            PORT_RLD_LO: in_port = rld_lo;
            PORT_RLD_HI: in_port = rld_hi;
            PORT_CTRL:   in_port = ctrl_rd(ctrl);
            PORT_STAT:   in_port = rd_stat;
            PORT_MASK:   in_port = mask;
            default:     in_port = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_io_responder.sv
module tb_io_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       io_strb;
    logic [7:0] in_port;
    logic       interrupt;
    logic [7:0] switches;
    logic [3:0] buttons;
    logic [7:0] leds;

    int checks = 0;
    int errors = 0;

    io_responder #(.NUM_BTN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .port_id   (port_id),
        .out_port  (out_port),
        .io_strb   (io_strb),
        .in_port   (in_port),
        .interrupt (interrupt),
        .switches  (switches),
        .buttons   (buttons),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id  = a;
        out_port = d;
        io_strb  = 1'b1;
        @(posedge clk);
        #1;
        io_strb  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        port_id = a;
        #1;
        d = in_port;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        logic [7:0] addrs [8];
        addrs = '{8'h20, 8'h21, 8'h40, 8'h80, 8'h81, 8'h82, 8'h83, 8'h84};
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        if (leds !== 8'h00) begin
            errors++; $display("FAIL reset_leds got %h exp 00", leds);
        end
        checks++;
        if (interrupt !== 1'b0) begin
            errors++; $display("FAIL reset_int got %b exp 0", interrupt);
        end
        checks++;
        for (int i = 0; i < 8; i++) begin
            rd(addrs[i], v);
            if (v !== 8'h00) begin
                errors++; $display("FAIL reset_read port %h got %h exp 00", addrs[i], v);
            end
            checks++;
        end
    endtask

    task automatic test_led_rw();
        logic [7:0] v;
        wr(8'h40, 8'h5A);
        if (leds !== 8'h5A) begin
            errors++; $display("FAIL led_out got %h exp 5a", leds);
        end
        checks++;
        rd(8'h40, v);
        if (v !== 8'h5A) begin
            errors++; $display("FAIL led_read got %h exp 5a", v);
        end
        checks++;
        rd(8'h99, v);
        if (v !== 8'h00) begin
            errors++; $display("FAIL unmapped_read got %h exp 00", v);
        end
        checks++;
        wr(8'h99, 8'hFF);
        wr(8'h20, 8'hFF);
        wr(8'h41, 8'h11);
        if (leds !== 8'h5A) begin
            errors++; $display("FAIL unmapped_write_leds got %h exp 5a", leds);
        end
        checks++;
        rd(8'h20, v);
        if (v !== 8'h00) begin
            errors++; $display("FAIL ro_write_sw got %h exp 00", v);
        end
        checks++;
        wr(8'h80, 8'hC3);
        wr(8'h81, 8'h3C);
        wr(8'h84, 8'hA5);
        rd(8'h80, v);
        if (v !== 8'hC3) begin
            errors++; $display("FAIL reload_lo_read got %h exp c3", v);
        end
        checks++;
        rd(8'h81, v);
        if (v !== 8'h3C) begin
            errors++; $display("FAIL reload_hi_read got %h exp 3c", v);
        end
        checks++;
        rd(8'h84, v);
        if (v !== 8'hA5) begin
            errors++; $display("FAIL mask_read got %h exp a5", v);
        end
        checks++;
        wr(8'h84, 8'h00);
    endtask

    task automatic test_switches();
        logic [7:0] v;
        switches = 8'hA5;
        step();
        rd(8'h20, v);
        if (v !== 8'h00) begin
            errors++; $display("FAIL sw_sync1 got %h exp 00", v);
        end
        checks++;
        step();
        rd(8'h20, v);
        if (v !== 8'hA5) begin
            errors++; $display("FAIL sw_sync2 got %h exp a5", v);
        end
        checks++;
    endtask

    task automatic test_timer_auto();
        logic [7:0] v;
        logic [7:0] e;
        wr(8'h80, 8'h03);
        wr(8'h81, 8'h00);
        wr(8'h84, 8'h01);
        wr(8'h82, 8'h03);
        rd(8'h82, v);
        if (v !== 8'h03) begin
            errors++; $display("FAIL ctrl_read got %h exp 03", v);
        end
        checks++;
        for (int i = 1; i <= 4; i++) begin
            step();
            rd(8'h83, v);
            e = (i == 4) ? 8'h01 : 8'h00;
            if (v !== e || interrupt !== e[0]) begin
                errors++; $display("FAIL auto_first cyc %0d got %h/%b exp %h", i, v, interrupt, e);
            end
            checks++;
        end
        wr(8'h83, 8'h01);   // edge 5: clear
        rd(8'h83, v);
        if (v !== 8'h00 || interrupt !== 1'b0) begin
            errors++; $display("FAIL auto_clr got %h/%b exp 00/0", v, interrupt);
        end
        checks++;
        for (int i = 6; i <= 8; i++) begin
            step();
            rd(8'h83, v);
            e = (i == 8) ? 8'h01 : 8'h00;
            if (v !== e || interrupt !== e[0]) begin
                errors++; $display("FAIL auto_period cyc %0d got %h/%b exp %h", i, v, interrupt, e);
            end
            checks++;
        end
        wr(8'h82, 8'h00);
        wr(8'h83, 8'h01);
        for (int i = 0; i < 8; i++) step();
        rd(8'h83, v);
        if (v !== 8'h00) begin
            errors++; $display("FAIL stop_no_event got %h exp 00", v);
        end
        checks++;
    endtask

    task automatic test_coincident_w1c();
        logic [7:0] v;
        wr(8'h82, 8'h03);   // reload still 3, load at E0
        step();
        step();
        step();
        wr(8'h83, 8'h01);   // W1C on E4, same edge as expiry
        rd(8'h83, v);
        if (v !== 8'h01 || interrupt !== 1'b1) begin
            errors++; $display("FAIL set_wins got %h/%b exp 01/1", v, interrupt);
        end
        checks++;
        wr(8'h82, 8'h00);
        wr(8'h83, 8'h01);
    endtask

    task automatic test_timer_oneshot();
        logic [7:0] v;
        wr(8'h84, 8'h00);
        wr(8'h80, 8'h02);
        wr(8'h82, 8'h01);
        for (int i = 1; i <= 3; i++) begin
            step();
            rd(8'h83, v);
            if (v !== ((i == 3) ? 8'h01 : 8'h00)) begin
                errors++; $display("FAIL oneshot cyc %0d got %h", i, v);
            end
            checks++;
        end
        if (interrupt !== 1'b0) begin
            errors++; $display("FAIL masked_int got %b exp 0", interrupt);
        end
        checks++;
        rd(8'h82, v);
        if (v !== 8'h00) begin
            errors++; $display("FAIL oneshot_ctrl got %h exp 00", v);
        end
        checks++;
        wr(8'h84, 8'h01);
        if (interrupt !== 1'b1) begin
            errors++; $display("FAIL unmask_int got %b exp 1", interrupt);
        end
        checks++;
        wr(8'h83, 8'h01);
        for (int i = 0; i < 10; i++) step();
        rd(8'h83, v);
        if (v !== 8'h00) begin
            errors++; $display("FAIL oneshot_hold got %h exp 00", v);
        end
        checks++;
    endtask

    task automatic test_reload_while_running();
        logic [7:0] v;
        wr(8'h80, 8'h03);
        wr(8'h82, 8'h01);   // load 3 at E0
        wr(8'h80, 8'h10);   // E1: new reload must not disturb count
        step();
        step();
        rd(8'h83, v);
        if (v !== 8'h00) begin
            errors++; $display("FAIL reload_run_early got %h exp 00", v);
        end
        checks++;
        step();             // E4
        rd(8'h83, v);
        if (v !== 8'h01) begin
            errors++; $display("FAIL reload_run_event got %h exp 01", v);
        end
        checks++;
        wr(8'h83, 8'h01);
    endtask

    task automatic test_button();
        logic [7:0] v;
        wr(8'h84, 8'h08);
        buttons = 4'b0100;
        step();
        rd(8'h83, v);
        if (v !== 8'h00) begin
            errors++; $display("FAIL btn_edge1 got %h exp 00", v);
        end
        checks++;
        step();
        rd(8'h21, v);
        if (v !== 8'h04) begin
            errors++; $display("FAIL btn_sync_read got %h exp 04", v);
        end
        checks++;
        rd(8'h83, v);
        if (v !== 8'h00) begin
            errors++; $display("FAIL btn_edge2 got %h exp 00", v);
        end
        checks++;
        step();
        rd(8'h83, v);
        if (v !== 8'h08 || interrupt !== 1'b1) begin
            errors++; $display("FAIL btn_edge3 got %h/%b exp 08/1", v, interrupt);
        end
        checks++;
        step();
        rd(8'h83, v);
        if (v !== 8'h08) begin
            errors++; $display("FAIL btn_sticky got %h exp 08", v);
        end
        checks++;
        wr(8'h83, 8'h00);   // writing 0 has no effect
        rd(8'h83, v);
        if (v !== 8'h08) begin
            errors++; $display("FAIL w0_noeffect got %h exp 08", v);
        end
        checks++;
        buttons = 4'b0000;
        wr(8'h83, 8'h08);
        rd(8'h83, v);
        if (v !== 8'h00 || interrupt !== 1'b0) begin
            errors++; $display("FAIL btn_clr got %h/%b exp 00/0", v, interrupt);
        end
        checks++;
        buttons = 4'b0001;
        step(); step(); step();
        rd(8'h83, v);
        if (v !== 8'h02 || interrupt !== 1'b0) begin
            errors++; $display("FAIL btn0 got %h/%b exp 02/0", v, interrupt);
        end
        checks++;
        buttons = 4'b0000;
        wr(8'h83, 8'hFF);
        rd(8'h83, v);
        if (v !== 8'h00) begin
            errors++; $display("FAIL clr_all got %h exp 00", v);
        end
        checks++;
    endtask

    task automatic test_reset_midcount();
        logic [7:0] v;
        logic       bad;
        wr(8'h80, 8'h03);
        wr(8'h84, 8'h01);
        wr(8'h82, 8'h03);
        step(); step(); step(); step();   // status bit0 set at E4
        step();
        rd(8'h83, v);
        if (v !== 8'h01) begin
            errors++; $display("FAIL pre_rst_status got %h exp 01", v);
        end
        checks++;
        // Reset coincides with an LED write; reset must win
        rst      = 1'b1;
        port_id  = 8'h40;
        out_port = 8'hFF;
        io_strb  = 1'b1;
        step();
        rst      = 1'b0;
        io_strb  = 1'b0;
        if (leds !== 8'h00 || interrupt !== 1'b0) begin
            errors++; $display("FAIL rst_prio got %h/%b exp 00/0", leds, interrupt);
        end
        checks++;
        rd(8'h82, v);
        if (v !== 8'h00) begin
            errors++; $display("FAIL rst_ctrl got %h exp 00", v);
        end
        checks++;
        rd(8'h80, v);
        if (v !== 8'h00) begin
            errors++; $display("FAIL rst_reload got %h exp 00", v);
        end
        checks++;
        rd(8'h84, v);
        if (v !== 8'h00) begin
            errors++; $display("FAIL rst_mask got %h exp 00", v);
        end
        checks++;
        port_id = 8'h83;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (in_port !== 8'h00 || interrupt !== 1'b0) bad = 1'b1;
        end
        if (bad !== 1'b0) begin
            errors++; $display("FAIL rst_no_event got %b exp 0", bad);
        end
        checks++;
    endtask

    initial begin
        rst      = 1'b1;
        port_id  = 8'h00;
        out_port = 8'h00;
        io_strb  = 1'b0;
        switches = 8'h00;
        buttons  = 4'b0000;
        test_reset();
        test_led_rw();
        test_switches();
        test_timer_auto();
        test_coincident_w1c();
        test_timer_oneshot();
        test_reload_while_running();
        test_button();
        test_reset_midcount();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
